// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request in IDLE, services it after a fixed
// latency against a word-addressed RAM, and answers with a one-cycle ack.
module mem_responder #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int MEM_DEPTH         = 256,
  parameter int LATENCY           = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata,
  output logic                         busy,
  output logic                         ack,
  output logic [DATA_BUS_WIDTH-1:0]    rdata,
  output logic                         err
);

  localparam int AW    = ADDRESS_BUS_WIDTH;
  localparam int DW    = DATA_BUS_WIDTH;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW    = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            commit;
  logic            in_range;
  logic [AW+31:0]  addr_ext;
  logic [IDX_W-1:0] idx;

  logic [DW-1:0]   mem [MEM_DEPTH];

  // Range check runs on the zero-extended address so no upper bits are lost.
  assign addr_ext = {32'd0, addr_d};
  assign in_range = addr_ext < (AW + 32)'(MEM_DEPTH);
  assign idx      = addr_ext[IDX_W-1:0];

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    commit  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Commit uses the _d holding values so a LATENCY of 1 sees the fresh request.
    if (commit) begin
      ack_d = 1'b1;
      err_d = ~in_range;
      if (in_range && !we_d) rdata_d = mem[idx];
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the RAM array is deliberately kept out of reset; contents survive it.
  always_ff @(posedge clk) begin
    if (!reset && commit && in_range && we_d) mem[idx] <= wdata_d;
  end

  assign busy  = busy_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one LATENCY=2 and one LATENCY=1 instance
// share a request bus; a negedge monitor checks acks against queued expectations.
module tb_mem_responder;

  typedef struct {
    int          due;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        sel = 1'b0;
  int          lat = 2;

  logic        req_a, req_b;
  logic        busy_a, ack_a, err_a, busy_b, ack_b, err_b;
  logic [15:0] rdata_a, rdata_b;
  logic        busy_m, ack_m, err_m;
  logic [15:0] rdata_m;

  int   cyc = 0;
  int   total_checks = 0;
  int   bad_checks = 0;
  logic mon_on = 1'b0;
  logic abort_busy = 1'b0;
  exp_t sb[$];

  assign req_a   = req & ~sel;
  assign req_b   = req & sel;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign ack_m   = sel ? ack_b   : ack_a;
  assign err_m   = sel ? err_b   : err_a;
  assign rdata_m = sel ? rdata_b : rdata_a;

  mem_responder #(
    .ADDRESS_BUS_WIDTH(16), .DATA_BUS_WIDTH(16), .MEM_DEPTH(256), .LATENCY(2)
  ) dut_l2 (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_a), .ack(ack_a), .rdata(rdata_a), .err(err_a)
  );

  mem_responder #(
    .ADDRESS_BUS_WIDTH(16), .DATA_BUS_WIDTH(16), .MEM_DEPTH(256), .LATENCY(1)
  ) dut_l1 (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_b), .ack(ack_b), .rdata(rdata_b), .err(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called right after the accepting edge; ack is due at the LATENCY-th edge.
  task automatic expect_resp(input logic [15:0] rd, input logic er);
    exp_t e;
    e.due   = cyc + lat - 1;
    e.rdata = rd;
    e.err   = er;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rd, input logic exp_err);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    expect_resp(exp_rd, exp_err);
    @(negedge clk);
    req = 1'b0;
    drain();
  endtask

  // Monitor: every cycle compares busy/ack, and rdata/err on ack or idle zeros.
  initial begin
    logic exp_ack;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        exp_ack = (sb.size() != 0) && (sb[0].due == cyc);
        check("busy", busy_m, (sb.size() != 0) || abort_busy);
        check("ack", ack_m, exp_ack);
        if (exp_ack) begin
          e = sb.pop_front();
          check("ack_rdata", rdata_m, e.rdata);
          check("ack_err", err_m, e.err);
        end else begin
          check("idle_rdata", rdata_m, 0);
          check("idle_err", err_m, 0);
        end
      end
    end
  end

  initial begin
    logic        b2b_we    [4];
    logic [15:0] b2b_addr  [4];
    logic [15:0] b2b_wdata [4];
    logic [15:0] b2b_exp   [4];
    b2b_we    = '{1'b1, 1'b1, 1'b0, 1'b0};
    b2b_addr  = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
    b2b_wdata = '{16'h0011, 16'h0022, 16'h0000, 16'h0000};
    b2b_exp   = '{16'h0000, 16'h0000, 16'h0011, 16'h0022};

    // Reset for two cycles, then ten idle cycles under the monitor.
    @(posedge clk); #1;
    mon_on = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // LATENCY=2 instance
    xact(1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0);
    xact(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);
    xact(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    xact(1'b1, 16'h00FF, 16'h7777, 16'h0000, 1'b0);
    xact(1'b0, 16'h00FF, 16'h0000, 16'h7777, 1'b0);
    xact(1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1);
    xact(1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1);
    xact(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    xact(1'b1, 16'hFFFF, 16'hCAFE, 16'h0000, 1'b1);
    xact(1'b0, 16'h00FF, 16'h0000, 16'h7777, 1'b0);
    xact(1'b1, 16'h0006, 16'h6666, 16'h0000, 1'b0);

    // Inputs change during BUSY: captured read of 0x0005 must win.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0005; wdata = 16'h0000;
    @(posedge clk); #1;
    expect_resp(16'hBEEF, 1'b0);
    @(negedge clk);
    we = 1'b1; addr = 16'h0006; wdata = 16'hDEAD;
    @(negedge clk);
    req = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    xact(1'b0, 16'h0006, 16'h0000, 16'h6666, 1'b0);

    // Reset during BUSY aborts a write to 0x0010.
    xact(1'b1, 16'h0010, 16'h5555, 16'h0000, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'hAAAA;
    @(posedge clk); #1;
    abort_busy = 1'b1;
    @(negedge clk);
    req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    abort_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    xact(1'b0, 16'h0010, 16'h0000, 16'h5555, 1'b0);

    // LATENCY=1 instance, req held high across every ack.
    @(negedge clk);
    sel = 1'b1; lat = 1;
    @(negedge clk);
    req = 1'b1; we = b2b_we[0]; addr = b2b_addr[0]; wdata = b2b_wdata[0];
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      expect_resp(b2b_exp[k], 1'b0);
      @(negedge clk);
      if (k < 3) begin
        we = b2b_we[k+1]; addr = b2b_addr[k+1]; wdata = b2b_wdata[k+1];
      end else begin
        req = 1'b0;
      end
      @(posedge clk);
    end
    drain();
    xact(1'b1, 16'h0100, 16'h0BAD, 16'h0000, 1'b1);
    xact(1'b0, 16'h0001, 16'h0000, 16'h0011, 1'b0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
